// File: rtl/flash_loader_if.sv
// Host stream and memory-preload bus of the flash loader.
// The host (master) drives in_*; the loader (slave) returns in_ready and drives flash_*.
interface flash_loader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  flash_en;
    logic [ADDR_WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0]      flash_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, flash_en, flash_addr, flash_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, flash_en, flash_addr, flash_data
    );
endinterface

// File: rtl/flash_loader.sv
// Boot loader: writes a valid/ready word stream to consecutive preload addresses,
// tracks count and checksum, and holds the core in reset until the image is in.
module flash_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_STEP  = 4,
    parameter int MAX_WORDS  = 512,
    parameter int RST_HOLD   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    flash_loader_if.slave                  bus,
    output logic                           cpu_rst,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic [WIDTH-1:0]               checksum
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [CW-1:0]         MAX_C     = CW'(MAX_WORDS);
    localparam logic [HW-1:0]         HOLD_INIT = HW'((RST_HOLD > 1) ? RST_HOLD - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  accept;
    logic                  full;
    logic                  restart;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [HW-1:0]         hold_cnt;

    assign accept  = bus.in_valid && bus.in_ready;
    assign full    = (word_count == MAX_C);
    assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN counts as the first held cycle so cpu_rst drops RST_HOLD+1 cycles
    // after the last accept; with RST_HOLD==1 there is no HOLD cycle left.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (full)             state_nx = S_ERR;
                    else if (bus.in_last) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: state_nx = (RST_HOLD > 1) ? S_HOLD : S_DONE;
            S_HOLD: begin
                if (hold_cnt == '0) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        cpu_rst      = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            S_DRAIN, S_HOLD: busy = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // Write datapath: an overflowing word is swallowed, not written or counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count     <= '0;
            checksum       <= '0;
            next_addr      <= BASE_A;
            hold_cnt       <= '0;
            bus.flash_en   <= 1'b0;
            bus.flash_addr <= '0;
            bus.flash_data <= '0;
        end else begin
            bus.flash_en <= 1'b0;
            if (restart) begin
                word_count <= '0;
                checksum   <= '0;
                next_addr  <= BASE_A;
            end else if (accept && !full) begin
                bus.flash_en   <= 1'b1;
                bus.flash_addr <= next_addr;
                bus.flash_data <= bus.in_data;
                word_count     <= word_count + 1'b1;
                checksum       <= checksum + bus.in_data;
                next_addr      <= next_addr + STEP_A;
            end
            if (state == S_DRAIN) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: a default instance plus a tiny one
// (2-word limit, 3-bit wrapping address, 1-cycle hold) against a spec-level model.
module tb_flash_loader;
    localparam int W   = 32;
    localparam int AW0 = 11, BA0 = 0, ST0 = 4, MW0 = 512, RH0 = 3;
    localparam int AW1 = 3,  BA1 = 4, ST1 = 4, MW1 = 2,   RH1 = 1;
    localparam int CW0 = $clog2(MW0 + 1);
    localparam int CW1 = $clog2(MW1 + 1);

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic cpu_rst0, busy0, done0, error0;
    logic cpu_rst1, busy1, done1, error1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;
    logic [W-1:0]   sum0, sum1;

    int checks = 0;
    int errors = 0;
    int unsigned m_cnt [2];
    logic [W-1:0] m_sum [2];
    logic [63:0] s_fen, s_addr, s_data, s_ready, s_cpu, s_busy, s_done, s_err, s_cnt, s_sum;

    always #5 clk = ~clk;

    flash_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW0)) bus0 ();
    flash_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW1)) bus1 ();

    flash_loader #(.WIDTH(W), .ADDR_WIDTH(AW0), .BASE_ADDR(BA0), .ADDR_STEP(ST0),
                   .MAX_WORDS(MW0), .RST_HOLD(RH0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0), .cpu_rst(cpu_rst0),
        .busy(busy0), .done(done0), .error(error0), .word_count(cnt0), .checksum(sum0));

    flash_loader #(.WIDTH(W), .ADDR_WIDTH(AW1), .BASE_ADDR(BA1), .ADDR_STEP(ST1),
                   .MAX_WORDS(MW1), .RST_HOLD(RH1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1), .cpu_rst(cpu_rst1),
        .busy(busy1), .done(done1), .error(error1), .word_count(cnt1), .checksum(sum1));

    function automatic int unsigned p_mw(input int d);
        return (d == 0) ? MW0 : MW1;
    endfunction

    function automatic int p_rh(input int d);
        return (d == 0) ? RH0 : RH1;
    endfunction

    // Address of write number k: (BASE + k*STEP) mod 2^ADDR_WIDTH.
    function automatic logic [63:0] exp_addr(input int d, input int unsigned k);
        longint a;
        longint m;
        a = longint'((d == 0) ? BA0 : BA1) + longint'(k) * longint'((d == 0) ? ST0 : ST1);
        m = longint'(1) << ((d == 0) ? AW0 : AW1);
        return 64'(a % m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL d%0d %s: observed 0x%0h expected 0x%0h", d, tag, o, e);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic v, input logic [W-1:0] data, input logic l);
        if (d == 0) begin
            start0 = s; bus0.in_valid = v; bus0.in_data = data; bus0.in_last = l;
        end else begin
            start1 = s; bus1.in_valid = v; bus1.in_data = data; bus1.in_last = l;
        end
    endtask

    task automatic snap(input int d);
        if (d == 0) begin
            s_fen = 64'(bus0.flash_en);   s_addr = 64'(bus0.flash_addr); s_data = 64'(bus0.flash_data);
            s_ready = 64'(bus0.in_ready); s_cpu = 64'(cpu_rst0);         s_busy = 64'(busy0);
            s_done = 64'(done0);          s_err = 64'(error0);           s_cnt = 64'(cnt0);
            s_sum = 64'(sum0);
        end else begin
            s_fen = 64'(bus1.flash_en);   s_addr = 64'(bus1.flash_addr); s_data = 64'(bus1.flash_data);
            s_ready = 64'(bus1.in_ready); s_cpu = 64'(cpu_rst1);         s_busy = 64'(busy1);
            s_done = 64'(done1);          s_err = 64'(error1);           s_cnt = 64'(cnt1);
            s_sum = 64'(sum1);
        end
    endtask

    task automatic chk_reset(input int d);
        snap(d);
        chk(d, "rst_cpu", s_cpu, 1);   chk(d, "rst_fen", s_fen, 0);   chk(d, "rst_addr", s_addr, 0);
        chk(d, "rst_data", s_data, 0); chk(d, "rst_ready", s_ready, 0); chk(d, "rst_busy", s_busy, 0);
        chk(d, "rst_done", s_done, 0); chk(d, "rst_err", s_err, 0);   chk(d, "rst_cnt", s_cnt, 0);
        chk(d, "rst_sum", s_sum, 0);
    endtask

    task automatic do_start(input int d);
        drive(d, 1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(d, 1'b0, 1'b0, '0, 1'b0);
        m_cnt[d] = 0;
        m_sum[d] = '0;
        snap(d);
        chk(d, "start_cpu", s_cpu, 1);   chk(d, "start_busy", s_busy, 1);
        chk(d, "start_ready", s_ready, 1); chk(d, "start_done", s_done, 0);
        chk(d, "start_err", s_err, 0);   chk(d, "start_cnt", s_cnt, 0);
        chk(d, "start_sum", s_sum, 0);   chk(d, "start_fen", s_fen, 0);
    endtask

    task automatic push(input int d, input logic s, input logic v, input logic [W-1:0] data, input logic l);
        snap(d);
        chk(d, "ready_load", s_ready, 1);
        drive(d, s, v, data, l);
        tick();
        drive(d, 1'b0, 1'b0, '0, 1'b0);
        snap(d);
        if (!v) begin
            chk(d, "gap_fen", s_fen, 0);
            chk(d, "gap_cnt", s_cnt, 64'(m_cnt[d]));
        end else if (m_cnt[d] == p_mw(d)) begin
            chk(d, "ovf_err", s_err, 1);  chk(d, "ovf_fen", s_fen, 0);
            chk(d, "ovf_cpu", s_cpu, 1);  chk(d, "ovf_ready", s_ready, 0);
            chk(d, "ovf_cnt", s_cnt, 64'(m_cnt[d]));
            chk(d, "ovf_sum", s_sum, 64'(m_sum[d]));
        end else begin
            chk(d, "wr_fen", s_fen, 1);
            chk(d, "wr_addr", s_addr, exp_addr(d, m_cnt[d]));
            chk(d, "wr_data", s_data, 64'(data));
            m_cnt[d]++;
            m_sum[d] = m_sum[d] + data;
            chk(d, "wr_cnt", s_cnt, 64'(m_cnt[d]));
            chk(d, "wr_sum", s_sum, 64'(m_sum[d]));
            chk(d, "wr_cpu", s_cpu, 1);
            chk(d, "wr_ready", s_ready, l ? 64'd0 : 64'd1);
        end
    endtask

    // Cycle N+k after the last accept: cpu_rst must fall exactly at k = RST_HOLD+1.
    task automatic expect_release(input int d);
        for (int k = 2; k <= p_rh(d) + 1; k++) begin
            tick();
            snap(d);
            chk(d, "hold_fen", s_fen, 0);
            chk(d, "hold_ready", s_ready, 0);
            if (k <= p_rh(d)) begin
                chk(d, "hold_cpu", s_cpu, 1);
                chk(d, "hold_busy", s_busy, 1);
            end else begin
                chk(d, "rel_cpu", s_cpu, 0);  chk(d, "rel_done", s_done, 1);
                chk(d, "rel_busy", s_busy, 0); chk(d, "rel_err", s_err, 0);
                chk(d, "rel_cnt", s_cnt, 64'(m_cnt[d]));
                chk(d, "rel_sum", s_sum, 64'(m_sum[d]));
            end
        end
    endtask

    task automatic idle_done(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b0, 1'b1, W'($urandom), 1'b0);
            tick();
            drive(d, 1'b0, 1'b0, '0, 1'b0);
            snap(d);
            chk(d, "done_hold", s_done, 1);  chk(d, "done_cpu", s_cpu, 0);
            chk(d, "done_fen", s_fen, 0);    chk(d, "done_ready", s_ready, 0);
            chk(d, "done_cnt", s_cnt, 64'(m_cnt[d]));
            chk(d, "done_sum", s_sum, 64'(m_sum[d]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned len;
        logic [W-1:0] w;
        drive(0, 1'b0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, 1'b0);
        m_cnt[0] = 0; m_cnt[1] = 0; m_sum[0] = '0; m_sum[1] = '0;

        #2 rst = 1'b0;
        #10;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        snap(0);
        chk(0, "idle_ready", s_ready, 0);
        chk(0, "idle_cpu", s_cpu, 1);

        // Two-word image
        do_start(0);
        push(0, 1'b0, 1'b1, 32'd12345, 1'b0);
        push(0, 1'b0, 1'b1, 32'd678910, 1'b1);
        chk(0, "two_sum_const", s_sum, 64'd691255);
        expect_release(0);
        chk(0, "two_cnt_const", s_cnt, 64'd2);

        // Reload from DONE
        idle_done(0, 2);
        do_start(0);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b1);
        chk(0, "reload_addr", s_addr, 64'(BA0));
        expect_release(0);
        chk(0, "reload_cnt_const", s_cnt, 64'd1);

        // Gapped stream: valid 1,0,0,1,1 with last on the third word
        do_start(0);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b0);
        push(0, 1'b0, 1'b0, W'($urandom), 1'b0);
        push(0, 1'b0, 1'b0, W'($urandom), 1'b1);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b0);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b1);
        chk(0, "gap_last_addr", s_addr, 64'd8);
        expect_release(0);
        chk(0, "gap_cnt_const", s_cnt, 64'd3);

        // Checksum wrap
        do_start(0);
        push(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        push(0, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        chk(0, "wrap_sum_const", s_sum, 64'h1);
        expect_release(0);

        // Random images with random gaps; start pulses during LOAD must be ignored
        for (int img = 0; img < 6; img++) begin
            do_start(0);
            len = $urandom_range(1, 10);
            for (int unsigned i = 0; i < len; i++) begin
                while ($urandom_range(0, 2) == 0)
                    push(0, 1'($urandom_range(0, 1)), 1'b0, W'($urandom), 1'($urandom_range(0, 1)));
                w = W'($urandom);
                push(0, 1'($urandom_range(0, 3) == 0), 1'b1, w, 1'(i == len - 1));
            end
            expect_release(0);
            if ($urandom_range(0, 1) == 1) idle_done(0, 1);
        end

        // Overflow on the 2-word instance, then recovery via start
        do_start(1);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b0);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b0);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b0);
        chk(1, "ovf_cnt_const", s_cnt, 64'd2);
        drive(1, 1'b0, 1'b1, W'($urandom), 1'b0);
        tick();
        drive(1, 1'b0, 1'b0, '0, 1'b0);
        snap(1);
        chk(1, "err_stay", s_err, 1);
        chk(1, "err_cpu", s_cpu, 1);
        chk(1, "err_fen", s_fen, 0);
        chk(1, "err_cnt", s_cnt, 64'(m_cnt[1]));
        do_start(1);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b1);
        expect_release(1);

        // Address wrap on the 3-bit address instance: 4 then 0
        do_start(1);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b0);
        push(1, 1'b0, 1'b1, W'($urandom), 1'b1);
        chk(1, "wrap_addr_const", s_addr, 64'd0);
        expect_release(1);

        // Reset mid-load after 1 of 3 words
        do_start(0);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b0);
        rst = 1'b0;
        #1;
        snap(0);
        chk(0, "mid_fen", s_fen, 0);   chk(0, "mid_cpu", s_cpu, 1);
        chk(0, "mid_cnt", s_cnt, 0);   chk(0, "mid_sum", s_sum, 0);
        chk(0, "mid_busy", s_busy, 0); chk(0, "mid_ready", s_ready, 0);
        snap(1);
        chk(1, "mid_cpu", s_cpu, 1);   chk(1, "mid_done", s_done, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_cnt[0] = 0; m_cnt[1] = 0; m_sum[0] = '0; m_sum[1] = '0;
        tick();
        snap(0);
        chk(0, "post_rst_ready", s_ready, 0);
        do_start(0);
        push(0, 1'b0, 1'b1, W'($urandom), 1'b0);
        chk(0, "post_rst_addr", s_addr, 64'(BA0));
        push(0, 1'b0, 1'b1, W'($urandom), 1'b1);
        expect_release(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
